// File: rtl/shift_pipe_if.sv
// Command/result handshake bundle for shift_pipe.
// The slave modport is the block itself; the master modport is the command source and consumer.
interface shift_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_din;
  logic [2:0] in_shamt;
  logic       in_lr;
  logic       in_al;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_dout;
  logic       out_zero;
  logic       out_neg;

  modport master (
    output in_valid, in_din, in_shamt, in_lr, in_al, out_ready,
    input  in_ready, out_valid, out_dout, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_din, in_shamt, in_lr, in_al, out_ready,
    output in_ready, out_valid, out_dout, out_zero, out_neg
  );
endinterface

// File: rtl/shift_pipe.sv
// Registered 8-bit shifter: one operand register feeding a DEPTH-entry result FIFO with
// zero/negative flags, plus a wrapping count of completed output handshakes.
module shift_pipe #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  shift_pipe_if.slave      bus,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [7:0] dout;
    logic       zero;
    logic       neg;
  } entry_t;

  // Stage 1 operand register
  logic       r_s1_valid;
  logic [7:0] r_s1_din;
  logic [2:0] r_s1_shamt;
  logic       r_s1_lr;
  logic       r_s1_al;

  // Stage 2 result FIFO
  entry_t           r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic [CNT_W-1:0] r_op_count;

  logic       w_out_valid;
  logic       w_pop;
  logic       w_push;
  logic       w_full;
  logic       w_in_ready;
  logic       w_load;
  logic [7:0] w_shift;
  entry_t     w_entry;
  entry_t     w_head;

  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == FullCnt);
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_push      = r_s1_valid && (!w_full || w_pop);
  // Combinational from out_ready so a full pipe can pop, advance and accept in one cycle.
  assign w_in_ready  = !rst && (!r_s1_valid || w_push);
  assign w_load      = bus.in_valid && w_in_ready;

  always_comb begin
    w_shift = r_s1_din;
    unique case ({r_s1_lr, r_s1_al})
      2'b00, 2'b01: w_shift = r_s1_din << r_s1_shamt;
      2'b10:        w_shift = r_s1_din >> r_s1_shamt;
      2'b11:        w_shift = 8'($signed(r_s1_din) >>> r_s1_shamt);
      default:      w_shift = r_s1_din;
    endcase
  end

  always_comb begin
    w_entry.dout = w_shift;
    w_entry.zero = (w_shift == 8'h00);
    w_entry.neg  = w_shift[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_load) begin
      r_s1_valid <= 1'b1;
    end else if (w_push) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Operand fields carry no reset; they are qualified by r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_s1_din   <= bus.in_din;
      r_s1_shamt <= bus.in_shamt;
      r_s1_lr    <= bus.in_lr;
      r_s1_al    <= bus.in_al;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_head = '0;
    if (w_out_valid) begin
      w_head = r_mem[r_rptr];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_dout  = w_head.dout;
  assign bus.out_zero  = w_head.zero;
  assign bus.out_neg   = w_head.neg;
  assign op_count      = r_op_count;
  assign busy          = r_s1_valid || w_out_valid;

endmodule
